// File: rtl/writeback_stage.sv
// Writeback stage: retires one executed bundle per accept into register writes, a store handshake,
// a fetch redirect or a sticky halt. Optional retire counter guarded by WB_RETIRE_COUNT_EN.
module writeback_stage #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exValidIn,
  input  logic [DATA_W-1:0] aluResultIn,
  input  logic [DATA_W-1:0] aluResultSpecialIn,
  input  logic [REG_W-1:0]  destRegIn,
  input  logic              destRegValidIn,
  input  logic [REG_W-1:0]  destRegSpecialIn,
  input  logic              destRegSpecialValidIn,
  input  logic              isMemoryAccessDestIn,
  input  logic [ADDR_W-1:0] memoryAddressDestIn,
  input  logic              didJumpIn,
  input  logic [ADDR_W-1:0] jumpTargetIn,
  input  logic              killIn,
  input  logic              memWriteAckIn,
  output logic              wbStallOut,
  output logic              regWrEnA,
  output logic [REG_W-1:0]  regWrAddrA,
  output logic [DATA_W-1:0] regWrDataA,
  output logic              regWrEnB,
  output logic [REG_W-1:0]  regWrAddrB,
  output logic [DATA_W-1:0] regWrDataB,
  output logic              memWriteReqOut,
  output logic [ADDR_W-1:0] memWriteAddrOut,
  output logic [DATA_W-1:0] memWriteDataOut,
  output logic              redirectValidOut,
  output logic [ADDR_W-1:0] redirectTargetOut,
  output logic              haltOut
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]       retireCountOut
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STORE  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              wrA_q, wrA_d;
  logic              wrB_q, wrB_d;
  logic              redir_q, redir_d;
  logic              capture;
  logic              capture_store;

  logic [REG_W-1:0]  addrA_q, addrB_q;
  logic [DATA_W-1:0] dataA_q, dataB_q;
  logic [ADDR_W-1:0] stAddr_q, target_q;
  logic [DATA_W-1:0] stData_q;

  // A non-kill accept is the only event that loads payload registers.
  assign capture       = (state_q == IDLE) && exValidIn && !killIn;
  assign capture_store = capture && isMemoryAccessDestIn;

  always_comb begin
    state_d = state_q;
    wrA_d   = 1'b0;
    wrB_d   = 1'b0;
    redir_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (exValidIn) begin
          if (killIn) begin
            state_d = HALTED;
          end else begin
            // Special result wins when both ports target the same register.
            wrB_d   = destRegSpecialValidIn;
            wrA_d   = destRegValidIn && !isMemoryAccessDestIn &&
                      !(destRegSpecialValidIn && (destRegSpecialIn == destRegIn));
            redir_d = didJumpIn;
            if (isMemoryAccessDestIn) state_d = STORE;
          end
        end
      end
      STORE: begin
        if (memWriteAckIn) state_d = IDLE;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wrA_q   <= 1'b0;
      wrB_q   <= 1'b0;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wrA_q   <= wrA_d;
      wrB_q   <= wrB_d;
      redir_q <= redir_d;
    end
  end

  // Payload registers are cleared too so that every output reads 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrA_q  <= '0;
      dataA_q  <= '0;
      addrB_q  <= '0;
      dataB_q  <= '0;
      target_q <= '0;
    end else if (capture) begin
      addrA_q  <= destRegIn;
      dataA_q  <= aluResultIn;
      addrB_q  <= destRegSpecialIn;
      dataB_q  <= aluResultSpecialIn;
      target_q <= jumpTargetIn;
    end
  end

  // Store payload only loads on a store accept, so it stays stable through the ack wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stAddr_q <= '0;
      stData_q <= '0;
    end else if (capture_store) begin
      stAddr_q <= memoryAddressDestIn;
      stData_q <= aluResultIn;
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (capture) begin
      count_q <= count_q + 64'd1;
    end
  end

  assign retireCountOut = count_q;
`endif

  assign wbStallOut        = (state_q != IDLE);
  assign memWriteReqOut    = (state_q == STORE);
  assign haltOut           = (state_q == HALTED);
  assign memWriteAddrOut   = stAddr_q;
  assign memWriteDataOut   = stData_q;
  assign regWrEnA          = wrA_q;
  assign regWrAddrA        = addrA_q;
  assign regWrDataA        = dataA_q;
  assign regWrEnB          = wrB_q;
  assign regWrAddrB        = addrB_q;
  assign regWrDataB        = dataB_q;
  assign redirectValidOut  = redir_q;
  assign redirectTargetOut = target_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed scenarios plus randomized bundles checked
// against a bundle-level model; compile with WB_RETIRE_COUNT_EN to also check the retire counter.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exValidIn = 1'b0;
  logic [63:0] aluResultIn = '0, aluResultSpecialIn = '0;
  logic [3:0]  destRegIn = '0, destRegSpecialIn = '0;
  logic        destRegValidIn = 1'b0, destRegSpecialValidIn = 1'b0;
  logic        isMemoryAccessDestIn = 1'b0;
  logic [63:0] memoryAddressDestIn = '0;
  logic        didJumpIn = 1'b0;
  logic [63:0] jumpTargetIn = '0;
  logic        killIn = 1'b0;
  logic        memWriteAckIn = 1'b0;
  logic        wbStallOut, regWrEnA, regWrEnB, memWriteReqOut, redirectValidOut, haltOut;
  logic [3:0]  regWrAddrA, regWrAddrB;
  logic [63:0] regWrDataA, regWrDataB, memWriteAddrOut, memWriteDataOut, redirectTargetOut;
`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retireCountOut;
`endif

  writeback_stage #(.ADDR_W(64), .DATA_W(64), .REG_W(4)) dut (
    .clk(clk), .reset(reset), .exValidIn(exValidIn),
    .aluResultIn(aluResultIn), .aluResultSpecialIn(aluResultSpecialIn),
    .destRegIn(destRegIn), .destRegValidIn(destRegValidIn),
    .destRegSpecialIn(destRegSpecialIn), .destRegSpecialValidIn(destRegSpecialValidIn),
    .isMemoryAccessDestIn(isMemoryAccessDestIn), .memoryAddressDestIn(memoryAddressDestIn),
    .didJumpIn(didJumpIn), .jumpTargetIn(jumpTargetIn), .killIn(killIn),
    .memWriteAckIn(memWriteAckIn), .wbStallOut(wbStallOut),
    .regWrEnA(regWrEnA), .regWrAddrA(regWrAddrA), .regWrDataA(regWrDataA),
    .regWrEnB(regWrEnB), .regWrAddrB(regWrAddrB), .regWrDataB(regWrDataB),
    .memWriteReqOut(memWriteReqOut), .memWriteAddrOut(memWriteAddrOut),
    .memWriteDataOut(memWriteDataOut), .redirectValidOut(redirectValidOut),
    .redirectTargetOut(redirectTargetOut), .haltOut(haltOut)
`ifdef WB_RETIRE_COUNT_EN
    , .retireCountOut(retireCountOut)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res, resS, maddr, tgt;
    logic [3:0]  d, ds;
    logic        dv, dsv, mem, jmp, kill;
  } bundle_t;

  typedef struct {
    int          due;
    logic [63:0] a;
    logic [63:0] d;
  } exp_t;

  exp_t q[3][$];  // 0: port A, 1: port B, 2: redirect

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Model state as seen in the current cycle.
  bit          curBusy = 0, curHalt = 0;
  logic [63:0] curSA = '0, curSD = '0, curCount = '0;
  int          busyCnt = 0, stAckDly = 1, ackDelay = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pulse_chk(input int k, input string nm, input logic en,
                           input logic [63:0] a, input logic [63:0] d);
    exp_t e;
    while (q[k].size() > 0 && q[k][0].due < cyc) begin
      e = q[k].pop_front();
      check({nm, "_missing"}, 64'(0), 64'(1));
    end
    if (en) begin
      if (q[k].size() == 0) begin
        check({nm, "_unexpected"}, 64'(1), 64'(0));
      end else begin
        e = q[k].pop_front();
        check({nm, "_cycle"}, 64'(cyc), 64'(e.due));
        check({nm, "_addr"}, a, e.a);
        check({nm, "_data"}, d, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      pulse_chk(0, "portA", regWrEnA, 64'(regWrAddrA), regWrDataA);
      pulse_chk(1, "portB", regWrEnB, 64'(regWrAddrB), regWrDataB);
      pulse_chk(2, "redirect", redirectValidOut, 64'(0), redirectTargetOut);
      check("stall", 64'(wbStallOut), 64'(curBusy | curHalt));
      check("halt", 64'(haltOut), 64'(curHalt));
      check("storeReq", 64'(memWriteReqOut), 64'(curBusy));
      if (curBusy) begin
        check("storeAddr", memWriteAddrOut, curSA);
        check("storeData", memWriteDataOut, curSD);
      end
`ifdef WB_RETIRE_COUNT_EN
      check("retireCount", retireCountOut, curCount);
`endif
    end
  end

  task automatic drive(input bundle_t b);
    aluResultIn = b.res; aluResultSpecialIn = b.resS;
    destRegIn = b.d; destRegValidIn = b.dv;
    destRegSpecialIn = b.ds; destRegSpecialValidIn = b.dsv;
    isMemoryAccessDestIn = b.mem; memoryAddressDestIn = b.maddr;
    didJumpIn = b.jmp; jumpTargetIn = b.tgt; killIn = b.kill;
  endtask

  // One clock: predict the effect of the coming edge from the driven inputs, then take it.
  task automatic tick(output bit acc);
    bit nBusy, nHalt;
    logic [63:0] nSA, nSD, nCount;
    exp_t e;
    acc = 0;
    nBusy = curBusy; nHalt = curHalt; nSA = curSA; nSD = curSD; nCount = curCount;
    if (curBusy) memWriteAckIn = (busyCnt + 1 >= stAckDly);
    else         memWriteAckIn = 1'($urandom_range(0, 1));
    if (!curHalt) begin
      if (curBusy) begin
        busyCnt++;
        if (memWriteAckIn) nBusy = 0;
      end else if (exValidIn) begin
        acc = 1;
        if (killIn) begin
          nHalt = 1;
        end else begin
          nCount = curCount + 64'd1;
          if (destRegSpecialValidIn) begin
            e = '{due: cyc + 1, a: 64'(destRegSpecialIn), d: aluResultSpecialIn};
            q[1].push_back(e);
          end
          if (destRegValidIn && !isMemoryAccessDestIn &&
              !(destRegSpecialValidIn && destRegSpecialIn == destRegIn)) begin
            e = '{due: cyc + 1, a: 64'(destRegIn), d: aluResultIn};
            q[0].push_back(e);
          end
          if (didJumpIn) begin
            e = '{due: cyc + 1, a: 64'(0), d: jumpTargetIn};
            q[2].push_back(e);
          end
          if (isMemoryAccessDestIn) begin
            nBusy = 1; busyCnt = 0; stAckDly = ackDelay;
            nSA = memoryAddressDestIn; nSD = aluResultIn;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    curBusy = nBusy; curHalt = nHalt; curSA = nSA; curSD = nSD; curCount = nCount;
  endtask

  task automatic idle(input int n);
    bit acc;
    exValidIn = 0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic issue(input bundle_t b, input int ackDly);
    bit acc;
    int n;
    drive(b);
    exValidIn = 1;
    ackDelay = ackDly;
    acc = 0;
    n = 0;
    while (!acc && n < 60) begin
      tick(acc);
      n++;
    end
    if (!acc) check("accept_timeout", 64'(0), 64'(1));
    exValidIn = 0;
  endtask

  task automatic offer(input bundle_t b, input int n);
    bit acc;
    drive(b);
    exValidIn = 1;
    for (int i = 0; i < n; i++) tick(acc);
    exValidIn = 0;
  endtask

  task automatic do_reset();
    mon_en = 0;
    #2;
    reset = 1;
    exValidIn = 0;
    memWriteAckIn = 0;
    #1;
    check("rst_req", 64'(memWriteReqOut), 64'(0));
    check("rst_stall", 64'(wbStallOut), 64'(0));
    check("rst_halt", 64'(haltOut), 64'(0));
    check("rst_enA", 64'(regWrEnA), 64'(0));
    check("rst_enB", 64'(regWrEnB), 64'(0));
    check("rst_redir", 64'(redirectValidOut), 64'(0));
    check("rst_payload", memWriteAddrOut | memWriteDataOut | regWrDataA | regWrDataB |
          redirectTargetOut | 64'(regWrAddrA) | 64'(regWrAddrB), 64'(0));
`ifdef WB_RETIRE_COUNT_EN
    check("rst_count", retireCountOut, 64'(0));
`endif
    for (int k = 0; k < 3; k++) q[k].delete();
    curBusy = 0; curHalt = 0; curSA = '0; curSD = '0; curCount = '0; busyCnt = 0;
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    mon_en = 1;
  endtask

  function automatic bundle_t zero_b();
    bundle_t b;
    b.res = '0; b.resS = '0; b.maddr = '0; b.tgt = '0;
    b.d = '0; b.ds = '0; b.dv = 0; b.dsv = 0; b.mem = 0; b.jmp = 0; b.kill = 0;
    return b;
  endfunction

  function automatic bundle_t rand_b();
    bundle_t b;
    b.res = {$urandom, $urandom}; b.resS = {$urandom, $urandom};
    b.maddr = {$urandom, $urandom}; b.tgt = {$urandom, $urandom};
    b.d = 4'($urandom_range(0, 15));
    b.ds = ($urandom_range(0, 3) == 0) ? b.d : 4'($urandom_range(0, 15));
    b.dv = 1'($urandom_range(0, 1));
    b.dsv = ($urandom_range(0, 2) == 0);
    b.mem = ($urandom_range(0, 4) == 0);
    b.jmp = ($urandom_range(0, 3) == 0);
    b.kill = ($urandom_range(0, 59) == 0);
    return b;
  endfunction

  initial begin
    bundle_t b;
    do_reset();

    // ALU write
    b = zero_b(); b.d = 4'd3; b.res = 64'h1234; b.dv = 1;
    issue(b, 1);
    check("alu_en", 64'(regWrEnA), 64'(1));
    check("alu_addr", 64'(regWrAddrA), 64'(3));
    check("alu_data", regWrDataA, 64'h1234);
    check("alu_stall", 64'(wbStallOut), 64'(0));
    idle(1);
    check("alu_pulse_end", 64'(regWrEnA), 64'(0));

    // MUL pair, then same destination code
    b = zero_b(); b.d = 4'd0; b.res = 64'hA; b.dv = 1; b.ds = 4'd2; b.resS = 64'hB; b.dsv = 1;
    issue(b, 1);
    check("mul_enA", 64'(regWrEnA), 64'(1));
    check("mul_enB", 64'(regWrEnB), 64'(1));
    b.d = 4'd5; b.ds = 4'd5;
    issue(b, 1);
    check("same_enA", 64'(regWrEnA), 64'(0));
    check("same_enB", 64'(regWrEnB), 64'(1));
    check("same_dataB", regWrDataB, 64'hB);
    idle(1);

    // Store with ack on its third cycle, followed by a waiting register write
    b = zero_b(); b.mem = 1; b.maddr = 64'h1000; b.res = 64'hFF; b.d = 4'd9; b.dv = 1;
    issue(b, 3);
    check("st_req", 64'(memWriteReqOut), 64'(1));
    check("st_addr", memWriteAddrOut, 64'h1000);
    check("st_data", memWriteDataOut, 64'hFF);
    b = zero_b(); b.d = 4'd7; b.res = 64'h77; b.dv = 1;
    issue(b, 1);
    check("after_st_enA", 64'(regWrEnA), 64'(1));
    check("after_st_req", 64'(memWriteReqOut), 64'(0));

    // Back-to-back taken jumps
    b = zero_b(); b.jmp = 1; b.tgt = 64'h400080;
    issue(b, 1);
    check("jmp1_valid", 64'(redirectValidOut), 64'(1));
    check("jmp1_target", redirectTargetOut, 64'h400080);
    b.tgt = 64'h500000;
    issue(b, 1);
    check("jmp2_valid", 64'(redirectValidOut), 64'(1));
    check("jmp2_target", redirectTargetOut, 64'h500000);
    idle(2);

    // Kill is sticky until reset
    b = zero_b(); b.kill = 1; b.dv = 1; b.d = 4'd4; b.res = 64'h55;
    issue(b, 1);
    check("kill_enA", 64'(regWrEnA), 64'(0));
    offer(rand_b(), 4);
    check("kill_halt", 64'(haltOut), 64'(1));
    check("kill_stall", 64'(wbStallOut), 64'(1));
    do_reset();

    // Reset while a store waits for its ack
    b = zero_b(); b.mem = 1; b.maddr = 64'h2000; b.res = 64'h33;
    issue(b, 50);
    idle(2);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      issue(rand_b(), $urandom_range(1, 4));
      if (curHalt) begin
        offer(rand_b(), 3);
        do_reset();
      end else if (curBusy && $urandom_range(0, 19) == 0) begin
        do_reset();
      end
    end
    idle(8);
    for (int k = 0; k < 3; k++) check("drain", 64'(q[k].size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage; the consumer of the execute stage's result bundle.
- Retires one executed instruction at a time:
  - writes register results (primary and special/RDX) to the register file;
  - issues memory stores through a req/ack handshake;
  - emits a one-cycle fetch redirect for taken jumps;
  - latches halt on return/kill.
- Drives wbStallOut back to execute while a store is outstanding.

Parameters:
- ADDR_W, 64, width of memory address and redirect target
- DATA_W, 64, width of ALU results and store data
- REG_W, 4, register code width (16 architectural GPRs)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- exValidIn  in  1  execute result valid (execute's isExecuteSuccessfulOut)
- aluResultIn  in  DATA_W  primary result
- aluResultSpecialIn  in  DATA_W  special result (MUL high half)
- destRegIn  in  REG_W  primary destination code
- destRegValidIn  in  1  primary destination valid
- destRegSpecialIn  in  REG_W  special destination code
- destRegSpecialValidIn  in  1  special destination valid
- isMemoryAccessDestIn  in  1  destination is memory
- memoryAddressDestIn  in  ADDR_W  store address
- didJumpIn  in  1  taken branch
- jumpTargetIn  in  ADDR_W  branch target
- killIn  in  1  halt request
- memWriteAckIn  in  1  store accepted by memory
- wbStallOut  out  1  backpressure to execute
- regWrEnA / regWrAddrA / regWrDataA  out  1/REG_W/DATA_W  register write port A
- regWrEnB / regWrAddrB / regWrDataB  out  1/REG_W/DATA_W  register write port B (special)
- memWriteReqOut / memWriteAddrOut / memWriteDataOut  out  1/ADDR_W/DATA_W  store request
- redirectValidOut / redirectTargetOut  out  1/ADDR_W  fetch redirect
- haltOut  out  1  sticky halted indication

Behaviour:
- States: IDLE, STORE, HALTED. On reset: state=IDLE and every output 0.
- Accept: rising edge with state==IDLE and exValidIn==1. No other state accepts input.
- Accept, killIn=1:
  - next state HALTED;
  - haltOut=1 from the next cycle until reset;
  - no register, store or redirect side effects, even if other fields are valid.
- Accept, isMemoryAccessDestIn=1:
  - next state STORE;
  - memWriteAddrOut / memWriteDataOut registered from memoryAddressDestIn / aluResultIn;
  - memWriteReqOut=1 and wbStallOut=1 from the next cycle;
  - primary register write suppressed;
  - special write, if valid, still issues on port B in the cycle after accept.
- STORE:
  - req, addr and data held stable until memWriteAckIn is sampled high;
  - on that edge: next state IDLE, req=0, stall=0;
  - minimum store occupancy 1 cycle (ack already high on the first STORE cycle).
- Accept, register result:
  - regWrEnA pulses exactly 1 cycle, the cycle after accept, with registered addr/data;
  - port B likewise when destRegSpecialValidIn=1.
- Both ports valid with equal codes: only port B asserted (special wins).
- Accept, didJumpIn=1: redirectValidOut pulses 1 cycle after accept with the registered target. Combinable with a register write.
- memWriteAckIn outside STORE: ignored.
- exValidIn while wbStallOut=1: not accepted. Execute holds the bundle.
- HALTED: all inputs ignored; wbStallOut=1.
- Reset mid-store: request dropped at once (asynchronous), state IDLE, no retry.
- Pulse outputs (regWrEn*, redirectValidOut) default 0 every cycle they are not set.
- Latency: register/redirect 1 cycle; store completion 1 cycle + ack wait.
- Throughput: 1 instr/cycle for non-store traffic.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- When defined:
  - adds output retireCountOut (64 bits), reset 0;
  - +1 on each accepted non-kill instruction at the accept edge;
  - a store counts at accept, not at ack;
  - wraps 2^64-1 -> 0;
  - frozen in HALTED.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ALU write:
  - Stimulus: accept destReg=3, result 0x1234, valid.
  - Required: next cycle regWrEnA=1, addr 3, data 0x1234; following cycle regWrEnA=0; wbStallOut stays 0.
- MUL pair:
  - Stimulus: dest=0 result 0xA, special=2 value 0xB.
  - Required: A and B pulse together; same-code case (both 5) asserts only B, data 0xB.
- Store with ack after 3 cycles:
  - Stimulus: addr 0x1000, data 0xFF.
  - Required: req/stall high 3 cycles with stable addr/data; a new exValidIn offered during that time is not consumed and is accepted the cycle after stall drops.
- Taken jump:
  - Stimulus: target 0x400080.
  - Required: redirectValidOut one cycle with 0x400080; back-to-back accepts give back-to-back pulses.
- Kill:
  - Stimulus: killIn with destRegValid=1.
  - Required: no register write; haltOut=1 and wbStallOut=1 until reset. Reset asserted mid-STORE drops req within the same cycle, and all outputs return to 0.
